// File: rtl/burst_read_rr_arbiter.sv
// Round-robin share of one burst read port: requests and beats pass through with zero latency.
// Backpressure: out_wait_n is forwarded to the granted port only; all requests are held off during a burst.
module burst_read_rr_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int ADDR_WIDTH   = 25,
    parameter int DATA_WIDTH   = 16,
    parameter int BURST_LENGTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            in_rd,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] in_addr,
    output logic [NUM_PORTS-1:0]            in_wait_n,
    output logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_burst_done,
    output logic [DATA_WIDTH-1:0]           in_dout,
    output logic                            out_rd,
    output logic [ADDR_WIDTH-1:0]           out_addr,
    input  logic [DATA_WIDTH-1:0]           out_dout,
    input  logic                            out_wait_n,
    input  logic                            out_valid
);

    localparam int CW = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
    localparam int PW = $clog2(NUM_PORTS);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state;
    logic [NUM_PORTS-1:0]   grant_reg;
    logic [PW-1:0]          last_ptr;
    logic [CW-1:0]          beat_cnt;

    logic [NUM_PORTS-1:0]   grant;
    logic [PW-1:0]          grant_idx;
    logic [PW-1:0]          scan_idx;
    logic                   found;
    logic                   last_beat;

    // Scan starts just after the last winner so every requester is reached within NUM_PORTS bursts.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        scan_idx  = '0;
        found     = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            scan_idx = PW'((int'(last_ptr) + k) % NUM_PORTS);
            if (!found && in_rd[scan_idx]) begin
                found            = 1'b1;
                grant[scan_idx]  = 1'b1;
                grant_idx        = scan_idx;
            end
        end
    end

    always_comb begin
        out_rd    = 1'b0;
        out_addr  = '0;
        in_wait_n = '0;
        if (state == IDLE) begin
            out_rd    = |in_rd;
            in_wait_n = grant & {NUM_PORTS{out_wait_n}};
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant[i]) begin
                    out_addr = in_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end
    end

    assign last_beat     = (state == BURST) && out_valid && (beat_cnt == CW'(BURST_LENGTH - 1));
    assign in_valid      = ((state == BURST) && out_valid) ? grant_reg : '0;
    assign in_burst_done = last_beat ? grant_reg : '0;
    assign in_dout       = out_dout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_reg <= '0;
            last_ptr  <= PW'(NUM_PORTS - 1);
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_rd && out_wait_n) begin
                        state     <= BURST;
                        grant_reg <= grant;
                        last_ptr  <= grant_idx;
                        beat_cnt  <= '0;
                    end
                end
                BURST: begin
                    if (last_beat) begin
                        state     <= IDLE;
                        grant_reg <= '0;
                        beat_cnt  <= '0;
                    end else if (out_valid) begin
                        beat_cnt  <= beat_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_read_rr_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_burst_read_rr_arbiter;

    localparam int NP = 4;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BL = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NP-1:0]     in_rd;
    logic [NP*AW-1:0]  in_addr;
    logic [NP-1:0]     in_wait_n;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_burst_done;
    logic [DW-1:0]     in_dout;
    logic              out_rd;
    logic [AW-1:0]     out_addr;
    logic [DW-1:0]     out_dout;
    logic              out_wait_n;
    logic              out_valid;

    int checks = 0;
    int errors = 0;

    // model state: whether a burst is outstanding, who owns it, beats still owed, last winner
    bit m_busy;
    int m_owner;
    int m_left;
    int m_last;

    burst_read_rr_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH(BL)
    ) dut (
        .clock(clock), .reset(reset),
        .in_rd(in_rd), .in_addr(in_addr), .in_wait_n(in_wait_n), .in_valid(in_valid),
        .in_burst_done(in_burst_done), .in_dout(in_dout),
        .out_rd(out_rd), .out_addr(out_addr), .out_dout(out_dout),
        .out_wait_n(out_wait_n), .out_valid(out_valid)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs;
        in_rd      = '0;
        in_addr    = '0;
        out_wait_n = 1'b1;
        out_valid  = 1'b0;
        out_dout   = '0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic run_beats(input int n);
        for (int b = 0; b < n; b++) begin
            out_valid = 1'b1;
            out_dout  = DW'($urandom);
            @(posedge clock); #1;
        end
        out_valid = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        #1 reset = 1'b1;
        @(negedge clock);
        checks++;
        if (out_rd !== 1'b0 || out_addr !== '0 || in_wait_n !== '0 || in_valid !== '0 || in_burst_done !== '0) begin
            errors++;
            $display("FAIL reset_outputs out_rd=%b addr=%h wait_n=%b valid=%b done=%b, required all zero",
                     out_rd, out_addr, in_wait_n, in_valid, in_burst_done);
        end
        in_rd = 4'b0010;
        in_addr[1*AW +: AW] = 25'h0000ABC;
        #1;
        checks++;
        if (out_rd !== 1'b1 || in_wait_n !== 4'b0010 || out_addr !== 25'h0000ABC) begin
            errors++;
            $display("FAIL reset_passthrough out_rd=%b wait_n=%b addr=%h, required 1 0010 0000abc", out_rd, in_wait_n, out_addr);
        end
        in_rd = 4'b1001;
        #1;
        checks++;
        if (in_wait_n !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_port wait_n=%b, required 0001", in_wait_n);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_port;
        apply_reset();
        in_rd = 4'b0100;
        in_addr[2*AW +: AW] = 25'h0001234;
        @(negedge clock);
        checks++;
        if (out_rd !== 1'b1 || out_addr !== 25'h0001234 || in_wait_n !== 4'b0100) begin
            errors++;
            $display("FAIL single_issue out_rd=%b addr=%h wait_n=%b, required 1 0001234 0100", out_rd, out_addr, in_wait_n);
        end
        @(posedge clock); #1;
        in_rd = '0;
        for (int b = 0; b < BL; b++) begin
            out_valid = 1'b1;
            out_dout  = DW'($urandom);
            @(negedge clock);
            checks++;
            if (in_valid !== 4'b0100 || in_dout !== out_dout ||
                in_burst_done !== ((b == BL - 1) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL single_beat%0d valid=%b done=%b dout=%h, required 0100 last-only %h",
                         b, in_valid, in_burst_done, in_dout, out_dout);
            end
            @(posedge clock); #1;
        end
        out_valid = 1'b0;
    endtask

    task automatic test_all_ports_rr;
        int n;
        int prev_cyc;
        logic [NP-1:0] exp_g;
        apply_reset();
        n = 0;
        prev_cyc = -1;
        for (int i = 0; i < NP; i++) in_addr[i*AW +: AW] = AW'(32'h100 * i + 32'h10);
        in_rd = '1;
        out_valid = 1'b1;
        for (int cyc = 0; cyc < 8 * (BL + 1); cyc++) begin
            out_dout = DW'($urandom);
            @(negedge clock);
            if (out_rd) begin
                exp_g = NP'(1 << (n % NP));
                checks++;
                if (in_wait_n !== exp_g || out_addr !== AW'(32'h100 * (n % NP) + 32'h10)) begin
                    errors++;
                    $display("FAIL rr_grant%0d wait_n=%b addr=%h, required %b %h",
                             n, in_wait_n, out_addr, exp_g, AW'(32'h100 * (n % NP) + 32'h10));
                end
                if (prev_cyc >= 0) begin
                    checks++;
                    if (cyc - prev_cyc != BL + 1) begin
                        errors++;
                        $display("FAIL rr_spacing%0d gap=%0d, required %0d", n, cyc - prev_cyc, BL + 1);
                    end
                end
                prev_cyc = cyc;
                n++;
            end
            @(posedge clock); #1;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL rr_count grants=%0d, required 8", n);
        end
        idle_inputs();
        run_beats(BL);
    endtask

    task automatic test_wait_stall;
        apply_reset();
        in_rd = 4'b0010;
        in_addr[1*AW +: AW] = 25'h1ABCDEF;
        out_wait_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if (out_rd !== 1'b1 || out_addr !== 25'h1ABCDEF || in_wait_n !== 4'b0000) begin
                errors++;
                $display("FAIL stall_cycle%0d out_rd=%b addr=%h wait_n=%b, required 1 1abcdef 0000", c, out_rd, out_addr, in_wait_n);
            end
            @(posedge clock); #1;
        end
        out_wait_n = 1'b1;
        @(negedge clock);
        checks++;
        if (in_wait_n !== 4'b0010 || out_rd !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept wait_n=%b out_rd=%b, required 0010 1", in_wait_n, out_rd);
        end
        @(posedge clock); #1;
        in_rd = '0;
        run_beats(BL);
    endtask

    task automatic test_holdoff;
        apply_reset();
        in_rd = 4'b0001;
        in_addr[3*AW +: AW] = 25'h0F00D33;
        @(negedge clock);
        checks++;
        if (in_wait_n !== 4'b0001) begin
            errors++;
            $display("FAIL holdoff_accept0 wait_n=%b, required 0001", in_wait_n);
        end
        @(posedge clock); #1;
        in_rd = 4'b1000;
        for (int b = 0; b < BL; b++) begin
            out_valid = 1'b1;
            @(negedge clock);
            checks++;
            if (out_rd !== 1'b0 || in_wait_n !== 4'b0000 || in_valid !== 4'b0001 ||
                in_burst_done !== ((b == BL - 1) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL holdoff_beat%0d out_rd=%b wait_n=%b valid=%b done=%b, required 0 0000 0001 last-only",
                         b, out_rd, in_wait_n, in_valid, in_burst_done);
            end
            @(posedge clock); #1;
        end
        out_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (out_rd !== 1'b1 || in_wait_n !== 4'b1000 || out_addr !== 25'h0F00D33) begin
            errors++;
            $display("FAIL holdoff_issue3 out_rd=%b wait_n=%b addr=%h, required 1 1000 0f00d33", out_rd, in_wait_n, out_addr);
        end
        @(posedge clock); #1;
        in_rd = '0;
        out_valid = 1'b1;
        @(negedge clock);
        checks++;
        if (in_valid !== 4'b1000) begin
            errors++;
            $display("FAIL holdoff_owner3 valid=%b, required 1000", in_valid);
        end
        @(posedge clock); #1;
        run_beats(BL - 1);
    endtask

    task automatic test_spurious;
        apply_reset();
        out_valid = 1'b1;
        out_dout  = 16'hBEEF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checks++;
            if (in_valid !== '0 || in_burst_done !== '0 || in_dout !== 16'hBEEF) begin
                errors++;
                $display("FAIL spurious%0d valid=%b done=%b dout=%h, required 0000 0000 beef", c, in_valid, in_burst_done, in_dout);
            end
            @(posedge clock); #1;
        end
        out_valid = 1'b0;
        in_rd = 4'b0010;
        @(posedge clock); #1;
        in_rd = '0;
        for (int b = 0; b < BL; b++) begin
            out_valid = 1'b1;
            @(negedge clock);
            checks++;
            if (in_burst_done !== ((b == BL - 1) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL spurious_count beat%0d done=%b, required done only on beat %0d", b, in_burst_done, BL - 1);
            end
            @(posedge clock); #1;
        end
        out_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst;
        apply_reset();
        in_rd = 4'b0100;
        @(posedge clock); #1;
        in_rd = '0;
        run_beats(2);
        out_valid = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if (in_valid !== '0 || in_burst_done !== '0 || out_rd !== 1'b0 || in_wait_n !== '0) begin
            errors++;
            $display("FAIL midreset_outputs valid=%b done=%b out_rd=%b wait_n=%b, required all zero",
                     in_valid, in_burst_done, out_rd, in_wait_n);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        out_valid = 1'b0;
        in_rd = '1;
        @(negedge clock);
        checks++;
        if (in_wait_n !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_restart wait_n=%b, required 0001", in_wait_n);
        end
        @(posedge clock); #1;
        in_rd = '0;
        run_beats(BL);
    endtask

    task automatic test_random;
        int win;
        int p;
        logic              exp_rd;
        logic [AW-1:0]     exp_addr;
        logic [NP-1:0]     exp_wait, exp_valid, exp_done;
        apply_reset();
        m_busy = 1'b0; m_owner = 0; m_left = 0; m_last = NP - 1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_rd      = NP'($urandom);
            for (int i = 0; i < NP; i++) in_addr[i*AW +: AW] = AW'($urandom);
            out_wait_n = ($urandom_range(0, 3) != 0);
            out_valid  = ($urandom_range(0, 2) != 0);
            out_dout   = DW'($urandom);
            @(negedge clock);
            win = -1;
            if (!m_busy) begin
                for (int k = 1; k <= NP; k++) begin
                    p = (m_last + k) % NP;
                    if (win < 0 && in_rd[p]) win = p;
                end
            end
            exp_rd    = !m_busy && (in_rd != 0);
            exp_addr  = (win >= 0) ? in_addr[win*AW +: AW] : '0;
            exp_wait  = (win >= 0 && out_wait_n) ? NP'(1 << win) : '0;
            exp_valid = (m_busy && out_valid) ? NP'(1 << m_owner) : '0;
            exp_done  = (m_busy && out_valid && m_left == 1) ? NP'(1 << m_owner) : '0;
            checks++;
            if (out_rd !== exp_rd || out_addr !== exp_addr || in_wait_n !== exp_wait ||
                in_valid !== exp_valid || in_burst_done !== exp_done || in_dout !== out_dout) begin
                errors++;
                $display("FAIL random_cycle%0d rd=%b addr=%h wait_n=%b valid=%b done=%b, required %b %h %b %b %b",
                         cyc, out_rd, out_addr, in_wait_n, in_valid, in_burst_done,
                         exp_rd, exp_addr, exp_wait, exp_valid, exp_done);
            end
            @(posedge clock);
            if (!m_busy) begin
                if (win >= 0 && out_wait_n) begin
                    m_busy = 1'b1; m_owner = win; m_last = win; m_left = BL;
                end
            end else if (out_valid) begin
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_port();
        test_all_ports_rr();
        test_wait_stall();
        test_holdoff();
        test_spurious();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
